mux_x16_rr_sched: RTL

MUX_X16_RR_SCHED -- requirements
Module: mux_x16_rr_sched

---
 rtl/mux_x16_rr_sched.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mux_x16_rr_sched.sv
// Round-robin scheduler over 16 single-bit requesters with burst-limited grants
// and a valid/ready output stage, selecting data through a 16:1 mux.
module mux_x16_rr_sched #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic [15:0] in,
  output logic [3:0]  c,
  output logic [15:0] gnt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_data,
  output logic        busy
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t      state, state_n;
  logic [3:0]  ptr, ptr_n, beat_cnt, beat_n, c_n;
  logic [15:0] gnt_n;
  logic        valid_n;
  logic [3:0]  arb_base, idx, winner;
  logic        found, any_req, xfer, last_beat, grant_end;

  // At grant end the scan must already start from c+1, in the same cycle ptr is updated.
  always_comb begin
    arb_base = (state == SERVE) ? c + 4'd1 : ptr;
    winner   = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      idx = arb_base + 4'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req   = |req;
  assign xfer      = out_valid & out_ready;
  assign last_beat = ({1'b0, beat_cnt} + 5'd1) == 5'(MAX_BURST);
  assign grant_end = (state == SERVE) && (xfer ? (last_beat || !req[c]) : !req[c]);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    beat_n  = beat_cnt;
    c_n     = c;
    gnt_n   = gnt;
    valid_n = out_valid;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_n = SERVE;
          c_n     = winner;
          gnt_n   = 16'd1 << winner;
          valid_n = 1'b1;
          beat_n  = '0;
        end
      end
      SERVE: begin
        if (grant_end) begin
          ptr_n = c + 4'd1;
          if (any_req) begin
            c_n    = winner;
            gnt_n  = 16'd1 << winner;
            beat_n = '0;
          end else begin
            state_n = IDLE;
            valid_n = 1'b0;
            gnt_n   = '0;
            beat_n  = '0;
          end
        end else if (xfer) begin
          beat_n = beat_cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      beat_cnt  <= '0;
      c         <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      beat_cnt  <= beat_n;
      c         <= c_n;
      gnt       <= gnt_n;
      out_valid <= valid_n;
    end
  end

  assign busy = (state == SERVE);

  MuxX16 u_mux (
    .in  (in),
    .c   (c),
    .out (out_data)
  );

endmodule

// 16:1 single-bit multiplexer.
module MuxX16 (
  input  logic [15:0] in,
  input  logic [3:0]  c,
  output logic        out
);
  assign out = in[c];
endmodule
